// File: rtl/rc_pkg.sv
// Shared types and constants for the game-round sequencer: state encoding,
// prompt direction codes and the LFSR output field layout.
package rc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        STEP,
        LATCH,
        WAIT,
        OVER
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam int LFSR_DIR_LSB = 0;
    localparam int LFSR_DIR_MSB = 1;
    localparam int LFSR_NOT_BIT = 2;

    localparam int TIME_W = 20;

    // A "NOT" prompt inverts the sense of the direction match.
    function automatic logic answer_ok(input logic [1:0] key,
                                       input logic [1:0] dir,
                                       input logic       inv);
        return (key == dir) ^ inv;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Per-round response timer: computes the shrinking response window from the
// score, loads it at the start of a round and counts it down to zero.
module round_timer
    import rc_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
    parameter logic [19:0] STEP_DEC       = 20'd20000,
    parameter logic [19:0] MIN_CYCLES     = 20'd250000,
    parameter int          SCORE_WIDTH    = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   i_load,
    input  logic                   i_dec,
    input  logic [SCORE_WIDTH-1:0] i_score,
    output logic [TIME_W-1:0]      o_time_left,
    output logic                   o_last
);

    // Wide enough that score*STEP_DEC never overflows and the difference keeps a sign bit.
    localparam int PW = TIME_W + SCORE_WIDTH + 2;

    logic        [PW-1:0]     w_prod;
    logic signed [PW-1:0]     w_diff;
    logic        [TIME_W-1:0] w_window;
    logic        [TIME_W-1:0] r_time_left;

    function automatic logic [TIME_W-1:0] clamp_window(input logic signed [PW-1:0] diff);
        if (diff < $signed(PW'(MIN_CYCLES))) begin
            return MIN_CYCLES;
        end
        return diff[TIME_W-1:0];
    endfunction

    always_comb begin
        w_prod   = PW'(i_score) * PW'(STEP_DEC);
        w_diff   = $signed(PW'(TIMEOUT_CYCLES)) - $signed(w_prod);
        w_window = clamp_window(w_diff);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_time_left <= '0;
        end else if (i_load) begin
            r_time_left <= w_window;
        end else if (i_dec && (r_time_left != '0)) begin
            r_time_left <= r_time_left - TIME_W'(1);
        end
    end

    assign o_time_left = r_time_left;
    assign o_last      = (r_time_left == TIME_W'(1));

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer: steps the LFSR for each prompt, times the response,
// checks the key press, keeps score and declares game over.
module round_controller
    import rc_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
    parameter logic [19:0] STEP_DEC       = 20'd20000,
    parameter logic [19:0] MIN_CYCLES     = 20'd250000,
    parameter int          SCORE_WIDTH    = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   key_valid,
    input  logic [1:0]             key_dir,
    input  logic [2:0]             lfsr_value,
    output logic                   lfsr_enable,
    output logic                   lfsr_reset,
    output logic                   prompt_valid,
    output logic [1:0]             prompt_dir,
    output logic                   prompt_not,
    output logic [TIME_W-1:0]      time_left,
    output logic [SCORE_WIDTH-1:0] score,
    output logic                   game_over
);

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_correct;
    logic                   w_last;
    logic                   w_begin;
    logic                   r_prompt_valid;
    logic [1:0]             r_prompt_dir;
    logic                   r_prompt_not;
    logic [SCORE_WIDTH-1:0] r_score;
    logic                   r_game_over;

    function automatic logic [SCORE_WIDTH-1:0] sat_inc(input logic [SCORE_WIDTH-1:0] s);
        return (s == '1) ? s : s + SCORE_WIDTH'(1);
    endfunction

    assign w_correct = answer_ok(key_dir, r_prompt_dir, r_prompt_not);
    assign w_begin   = ((r_state == IDLE) || (r_state == OVER)) && start;

    always_comb begin
        w_next      = r_state;
        lfsr_enable = 1'b0;
        lfsr_reset  = 1'b0;
        unique case (r_state)
            IDLE, OVER: if (start) w_next = SEED;
            SEED: begin
                lfsr_enable = 1'b1;
                lfsr_reset  = 1'b1;
                w_next      = STEP;
            end
            STEP: begin
                lfsr_enable = 1'b1;
                w_next      = LATCH;
            end
            LATCH: w_next = WAIT;
            WAIT: begin
                // A key press in the final cycle still counts: key beats timeout.
                if (key_valid) begin
                    w_next = w_correct ? STEP : OVER;
                end else if (w_last) begin
                    w_next = OVER;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= IDLE;
            r_prompt_valid <= 1'b0;
            r_prompt_dir   <= 2'd0;
            r_prompt_not   <= 1'b0;
            r_score        <= '0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_prompt_valid <= (w_next == WAIT);
            if (r_state == LATCH) begin
                r_prompt_dir <= lfsr_value[LFSR_DIR_MSB:LFSR_DIR_LSB];
                r_prompt_not <= lfsr_value[LFSR_NOT_BIT];
            end
            if (w_begin) begin
                r_score     <= '0;
                r_game_over <= 1'b0;
            end else if ((r_state == WAIT) && key_valid && w_correct) begin
                r_score <= sat_inc(r_score);
            end else if ((r_state == WAIT) && (w_next == OVER)) begin
                r_game_over <= 1'b1;
            end
        end
    end

    round_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .STEP_DEC       (STEP_DEC),
        .MIN_CYCLES     (MIN_CYCLES),
        .SCORE_WIDTH    (SCORE_WIDTH)
    ) u_timer (
        .clock       (clock),
        .resetn      (resetn),
        .i_load      (r_state == LATCH),
        .i_dec       (r_state == WAIT),
        .i_score     (r_score),
        .o_time_left (time_left),
        .o_last      (w_last)
    );

    assign prompt_valid = r_prompt_valid;
    assign prompt_dir   = r_prompt_dir;
    assign prompt_not   = r_prompt_not;
    assign score        = r_score;
    assign game_over    = r_game_over;

endmodule

// File: tb/tb_round_controller.sv
// Scoreboard bench for round_controller: a rule-level game model predicts each
// prompt and each game-over event; a monitor pops and compares them.
module tb_round_controller;

    // A 4-bit score lets saturation and the below-floor / negative window clamp both occur.
    localparam int SW   = 4;
    localparam int T0   = 20;
    localparam int SD   = 2;
    localparam int MN   = 6;
    localparam int SMAX = (1 << SW) - 1;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          key_valid = 1'b0;
    logic [1:0]    key_dir = 2'd0;
    logic [2:0]    lfsr_value;
    logic          lfsr_enable;
    logic          lfsr_reset;
    logic          prompt_valid;
    logic [1:0]    prompt_dir;
    logic          prompt_not;
    logic [19:0]   time_left;
    logic [SW-1:0] score;
    logic          game_over;

    round_controller #(
        .TIMEOUT_CYCLES (20'd20),
        .STEP_DEC       (20'd2),
        .MIN_CYCLES     (20'd6),
        .SCORE_WIDTH    (SW)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .key_valid    (key_valid),
        .key_dir      (key_dir),
        .lfsr_value   (lfsr_value),
        .lfsr_enable  (lfsr_enable),
        .lfsr_reset   (lfsr_reset),
        .prompt_valid (prompt_valid),
        .prompt_dir   (prompt_dir),
        .prompt_not   (prompt_not),
        .time_left    (time_left),
        .score        (score),
        .game_over    (game_over)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // LFSR stand-in: seed load gives 0, each step presents the next scripted value.
    logic [2:0] lfsr_script[$];
    always @(posedge clock or negedge resetn) begin
        if (!resetn) lfsr_value <= 3'b000;
        else if (lfsr_enable) begin
            if (lfsr_reset) lfsr_value <= 3'b000;
            else if (lfsr_script.size() > 0) lfsr_value <= lfsr_script.pop_front();
            else lfsr_value <= 3'($urandom);
        end
    end

    typedef struct {
        int         at;
        logic [1:0] dir;
        logic       inv;
        int         tl;
        int         sc;
    } prm_t;

    typedef struct {
        int at;
        int sc;
        int tl;
    } ovr_t;

    prm_t exp_prm[$];
    ovr_t exp_ovr[$];

    int checks = 0;
    int errors = 0;

    int         m_score = 0;
    logic [2:0] m_cur = 3'b000;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int window_of(input int s);
        int w;
        w = T0 - s * SD;
        return (w < MN) ? MN : w;
    endfunction

    function automatic logic [1:0] pick_key(input logic [2:0] v, input bit correct);
        logic [1:0] other;
        other = v[1:0] ^ 2'($urandom_range(1, 3));
        return (v[2] ^ correct) ? v[1:0] : other;
    endfunction

    task automatic push_prompt(input int at, input logic [2:0] v, input int sc);
        prm_t e;
        e.at  = at;
        e.dir = v[1:0];
        e.inv = v[2];
        e.tl  = window_of(sc);
        e.sc  = sc;
        exp_prm.push_back(e);
    endtask

    task automatic push_over(input int at, input int sc, input int tl);
        ovr_t e;
        e.at = at;
        e.sc = sc;
        e.tl = tl;
        exp_ovr.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_lfsr_enable"}, lfsr_enable, 0);
        chk({tag, "_lfsr_reset"}, lfsr_reset, 0);
        chk({tag, "_prompt_valid"}, prompt_valid, 0);
        chk({tag, "_prompt_dir"}, prompt_dir, 0);
        chk({tag, "_prompt_not"}, prompt_not, 0);
        chk({tag, "_time_left"}, time_left, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_game_over"}, game_over, 0);
    endtask

    task automatic wait_prompt();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (prompt_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("prompt_wait_timeout", 0, 1);
    endtask

    task automatic issue_start(input logic [2:0] v);
        @(negedge clock);
        start   = 1'b1;
        m_score = 0;
        m_cur   = v;
        lfsr_script.push_back(v);
        push_prompt(cyc + 4, v, 0);
        @(negedge clock);
        start = 1'b0;
        chk("seed_lfsr_enable", lfsr_enable, 1);
        chk("seed_lfsr_reset", lfsr_reset, 1);
        chk("start_score_cleared", score, 0);
        chk("start_game_over_cleared", game_over, 0);
        @(negedge clock);
        chk("step_lfsr_enable", lfsr_enable, 1);
        chk("step_lfsr_reset", lfsr_reset, 0);
        wait_prompt();
    endtask

    // Called on the first cycle of a live prompt; presses a key d cycles later.
    task automatic answer(input int d, input logic [1:0] key, input logic [2:0] v_next);
        int w;
        bit ok;
        w = window_of(m_score);
        repeat (d) @(negedge clock);
        chk("time_left_at_key", time_left, w - d);
        ok = m_cur[2] ? (key != m_cur[1:0]) : (key == m_cur[1:0]);
        key_valid = 1'b1;
        key_dir   = key;
        if (ok) begin
            if (m_score < SMAX) m_score++;
            m_cur = v_next;
            lfsr_script.push_back(v_next);
            push_prompt(cyc + 3, v_next, m_score);
        end else begin
            push_over(cyc + 1, m_score, -1);
        end
        @(negedge clock);
        key_valid = 1'b0;
        if (ok) wait_prompt();
    endtask

    task automatic let_time_out();
        int w;
        w = window_of(m_score);
        push_over(cyc + w, m_score, 0);
        repeat (w + 1) @(negedge clock);
    endtask

    // Monitor: compares every prompt and game-over onset against the model's queues.
    initial begin
        logic pv_d;
        logic go_d;
        prm_t p;
        ovr_t o;
        pv_d = 1'b0;
        go_d = 1'b0;
        forever begin
            @(negedge clock);
            if (prompt_valid && !pv_d) begin
                if (exp_prm.size() == 0) chk("unexpected_prompt", 1, 0);
                else begin
                    p = exp_prm.pop_front();
                    chk("prompt_cycle", cyc, p.at);
                    chk("prompt_dir", prompt_dir, p.dir);
                    chk("prompt_not", prompt_not, p.inv);
                    chk("prompt_time_left", time_left, p.tl);
                    chk("prompt_score", score, p.sc);
                end
            end
            if (game_over && !go_d) begin
                if (exp_ovr.size() == 0) chk("unexpected_game_over", 1, 0);
                else begin
                    o = exp_ovr.pop_front();
                    chk("over_cycle", cyc, o.at);
                    chk("over_score", score, o.sc);
                    chk("over_prompt_valid", prompt_valid, 0);
                    if (o.tl >= 0) chk("over_time_left", time_left, o.tl);
                end
            end
            pv_d = prompt_valid;
            go_d = game_over;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clock);
        resetn = 1'b1;

        // First game: plain prompt DOWN, then a wrong answer.
        issue_start(3'b010);
        answer(2, pick_key(m_cur, 0), 3'b000);
        repeat (2) @(negedge clock);

        // Restart from OVER: RIGHT answered 1, NOT-LEFT... NOT-RIGHT answered 3, then NOT-DOWN answered 2.
        issue_start(3'b001);
        answer(1, 2'd1, 3'b101);
        answer(3, 2'd3, 3'b110);
        chk("score_after_two", score, 2);
        answer(0, 2'd2, 3'b000);
        repeat (2) @(negedge clock);
        key_valid = 1'b1;
        key_dir   = 2'd0;
        @(negedge clock);
        key_valid = 1'b0;
        @(negedge clock);
        chk("over_key_ignored_score", score, 2);
        chk("over_key_ignored_game_over", game_over, 1);
        chk("over_lfsr_idle", lfsr_enable, 0);

        // Key in the last cycle of the window beats the timeout; then a real timeout.
        issue_start(3'($urandom));
        answer(window_of(0) - 1, pick_key(m_cur, 1), 3'($urandom));
        let_time_out();

        // Long game: window shrinks to the floor and the score saturates.
        issue_start(3'($urandom));
        for (int r = 0; r < SMAX + 2; r++) begin
            answer($urandom_range(0, window_of(m_score) - 1), pick_key(m_cur, 1), 3'($urandom));
        end
        chk("score_saturated", score, SMAX);
        chk("floor_window_time_left", time_left, MN);

        // start while a prompt is live must not restart the game.
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("mid_start_prompt_held", prompt_valid, 1);
        chk("mid_start_score_held", score, SMAX);

        // Asynchronous reset in the middle of a round.
        #2 resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clock);
        resetn = 1'b1;
        chk("queues_drained_prompt", exp_prm.size(), 0);
        chk("queues_drained_over", exp_ovr.size(), 0);

        issue_start(3'($urandom));
        answer($urandom_range(0, 5), pick_key(m_cur, 0), 3'b000);
        repeat (3) @(negedge clock);
        chk("final_prompt_queue_empty", exp_prm.size(), 0);
        chk("final_over_queue_empty", exp_ovr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
